// File: rtl/circuito_entrada.sv
// Input stage of the game: collects each player's choice, then presents the
// players one at a time to circuito_saida together with the choice flags.
module circuito_entrada #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       START,
  input  logic [1:0] JA,
  input  logic [1:0] JB,
  input  logic [1:0] JC,
  input  logic [1:0] JD,
  input  logic       EA,
  input  logic       EB,
  input  logic       EC,
  input  logic       ED,
  output logic       INA,
  output logic       INB,
  output logic       INC,
  output logic       IND,
  output logic       IN00,
  output logic       IN01,
  output logic       IN10,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_PRESENT,
    S_FINISH
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t          r_state;
  logic [3:0][1:0] r_choice;
  logic [3:0]      r_locked;
  logic            r_err;
  logic [2:0]      r_flags;
  logic [3:0]      r_sel;
  logic [7:0]      r_hold;
  logic [1:0]      r_idx;
  logic            r_done;
  logic            r_busy;

  state_t          w_state_nx;
  logic [3:0][1:0] w_choice_nx;
  logic [3:0]      w_locked_nx;
  logic            w_err_nx;
  logic [2:0]      w_flags_nx;
  logic [3:0]      w_sel_nx;
  logic [7:0]      w_hold_nx;
  logic [1:0]      w_idx_nx;
  logic            w_done_nx;

  logic [3:0][1:0] w_j;
  logic [3:0]      w_e;

  assign w_j = {JD, JC, JB, JA};
  assign w_e = {ED, EC, EB, EA};

  always_comb begin
    w_state_nx  = r_state;
    w_choice_nx = r_choice;
    w_locked_nx = r_locked;
    w_err_nx    = r_err;
    w_flags_nx  = r_flags;
    w_sel_nx    = r_sel;
    w_hold_nx   = r_hold;
    w_idx_nx    = r_idx;
    w_done_nx   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_nx  = S_COLLECT;
          w_choice_nx = '0;
          w_locked_nx = '0;
          w_err_nx    = 1'b0;
          w_flags_nx  = '0;
        end
      end
      S_COLLECT: begin
        if (&r_locked) begin
          w_state_nx = S_PRESENT;
          w_sel_nx   = 4'b0001;
          w_hold_nx  = '0;
          w_idx_nx   = '0;
          w_flags_nx = '0;
          for (int i = 0; i < 4; i++) begin
            if (r_choice[i] == 2'b00) w_flags_nx[0] = 1'b1;
            if (r_choice[i] == 2'b01) w_flags_nx[1] = 1'b1;
            if (r_choice[i] == 2'b10) w_flags_nx[2] = 1'b1;
          end
        end else begin
          // A code of 11 flags an error but keeps the player free to retry.
          for (int i = 0; i < 4; i++) begin
            if (w_e[i] && !r_locked[i]) begin
              if (w_j[i] == 2'b11) begin
                w_err_nx = 1'b1;
              end else begin
                w_choice_nx[i] = w_j[i];
                w_locked_nx[i] = 1'b1;
              end
            end
          end
        end
      end
      S_PRESENT: begin
        if (r_hold == HOLD_LAST) begin
          w_hold_nx = '0;
          if (r_idx == 2'd3) begin
            w_state_nx = S_FINISH;
            w_sel_nx   = '0;
            w_done_nx  = 1'b1;
          end else begin
            w_idx_nx = r_idx + 2'd1;
            w_sel_nx = {r_sel[2:0], 1'b0};
          end
        end else begin
          w_hold_nx = r_hold + 8'd1;
        end
      end
      S_FINISH: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_choice <= '0;
      r_locked <= '0;
      r_err    <= 1'b0;
      r_flags  <= '0;
      r_sel    <= '0;
      r_hold   <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_choice <= w_choice_nx;
      r_locked <= w_locked_nx;
      r_err    <= w_err_nx;
      r_flags  <= w_flags_nx;
      r_sel    <= w_sel_nx;
      r_hold   <= w_hold_nx;
      r_idx    <= w_idx_nx;
      r_done   <= w_done_nx;
      r_busy   <= (w_state_nx != S_IDLE);
    end
  end

  assign {IND, INC, INB, INA} = r_sel;
  assign {IN10, IN01, IN00}   = r_flags;
  assign BUSY = r_busy;
  assign DONE = r_done;
  assign ERR  = r_err;

endmodule

// File: tb/tb_circuito_entrada.sv
// Directed bench for circuito_entrada: default hold (dut0)
// and HOLD_CYCLES=1 (dut1) driven by shared inputs.
module tb_circuito_entrada;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [1:0] JA = '0, JB = '0, JC = '0, JD = '0;
  logic       EA = 1'b0, EB = 1'b0, EC = 1'b0, ED = 1'b0;

  logic ina0, inb0, inc0, ind0, f00_0, f01_0, f10_0;
  logic busy0, done0, err0;
  logic ina1, inb1, inc1, ind1, f00_1, f01_1, f10_1;
  logic busy1, done1, err1;

  logic [3:0] sel0, sel1;
  logic [2:0] flg0, flg1;
  assign sel0 = {ind0, inc0, inb0, ina0};
  assign sel1 = {ind1, inc1, inb1, ina1};
  assign flg0 = {f10_0, f01_0, f00_0};
  assign flg1 = {f10_1, f01_1, f00_1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  circuito_entrada #(.HOLD_CYCLES(10)) dut0 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .JA(JA), .JB(JB), .JC(JC), .JD(JD),
    .EA(EA), .EB(EB), .EC(EC), .ED(ED),
    .INA(ina0), .INB(inb0), .INC(inc0), .IND(ind0),
    .IN00(f00_0), .IN01(f01_0), .IN10(f10_0),
    .BUSY(busy0), .DONE(done0), .ERR(err0)
  );

  circuito_entrada #(.HOLD_CYCLES(1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .START(START),
    .JA(JA), .JB(JB), .JC(JC), .JD(JD),
    .EA(EA), .EB(EB), .EC(EC), .ED(ED),
    .INA(ina1), .INB(inb1), .INC(inc1), .IND(ind1),
    .IN00(f00_1), .IN01(f01_1), .IN10(f10_1),
    .BUSY(busy1), .DONE(done1), .ERR(err1)
  );

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    START = 1'b0;
    {ED, EC, EB, EA} = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] en,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] c, input logic [1:0] d);
    JA = a; JB = b; JC = c; JD = d;
    {ED, EC, EB, EA} = en;
    @(posedge CLK);
    #1;
    {ED, EC, EB, EA} = '0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({sel0, flg0, busy0, done0, err0} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset0: got %b expected 0",
               {sel0, flg0, busy0, done0, err0});
    end
    n_cmp++;
    if ({sel1, flg1, busy1, done1, err1} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset1: got %b expected 0",
               {sel1, flg1, busy1, done1, err1});
    end
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_basic();
    logic [3:0] exp;
    do_reset();
    pulse_start();
    @(negedge CLK);
    n_cmp++;
    if ({busy0, err0, flg0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL basic_collect: got %b expected 10000",
               {busy0, err0, flg0});
    end
    strobe(4'b0001, 2'b00, 2'b00, 2'b00, 2'b00);
    strobe(4'b0010, 2'b00, 2'b01, 2'b00, 2'b00);
    strobe(4'b0100, 2'b00, 2'b00, 2'b10, 2'b00);
    strobe(4'b1000, 2'b00, 2'b00, 2'b00, 2'b00);
    @(negedge CLK);
    n_cmp++;
    if (sel0 !== 4'b0000) begin
      n_bad++;
      $display("FAIL basic_prelock: got %b expected 0000", sel0);
    end
    @(posedge CLK);
    #1;
    for (int p = 0; p < 4; p++) begin
      exp = 4'b0001 << p;
      for (int k = 0; k < 10; k++) begin
        @(negedge CLK);
        n_cmp++;
        if (sel0 !== exp || done0 !== 1'b0) begin
          n_bad++;
          $display("FAIL basic_sel p%0d k%0d: got %b/%b expected %b/0",
                   p, k, sel0, done0, exp);
        end
        if (p == 0 && k == 0) begin
          n_cmp++;
          if (flg0 !== 3'b111) begin
            n_bad++;
            $display("FAIL basic_flags: got %b expected 111", flg0);
          end
        end
      end
    end
    @(negedge CLK);
    n_cmp++;
    if ({done0, busy0, sel0} !== 6'b110000) begin
      n_bad++;
      $display("FAIL basic_done: got %b expected 110000",
               {done0, busy0, sel0});
    end
    @(negedge CLK);
    n_cmp++;
    if ({done0, busy0, flg0} !== 5'b00111) begin
      n_bad++;
      $display("FAIL basic_idle: got %b expected 00111",
               {done0, busy0, flg0});
    end
  endtask

  task automatic test_simul();
    do_reset();
    pulse_start();
    strobe(4'b1111, 2'b01, 2'b01, 2'b01, 2'b01);
    @(negedge CLK);
    n_cmp++;
    if ({busy0, sel0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL simul_lock: got %b expected 10000", {busy0, sel0});
    end
    @(negedge CLK);
    n_cmp++;
    if ({sel0, flg0} !== 7'b0001010) begin
      n_bad++;
      $display("FAIL simul_present: got %b expected 0001010",
               {sel0, flg0});
    end
  endtask

  task automatic test_err();
    do_reset();
    pulse_start();
    strobe(4'b0001, 2'b11, 2'b00, 2'b00, 2'b00);
    @(negedge CLK);
    n_cmp++;
    if (err0 !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got %b expected 1", err0);
    end
    strobe(4'b1110, 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({busy0, sel0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL err_unlocked: got %b expected 10000",
               {busy0, sel0});
    end
    @(posedge CLK);
    #1;
    strobe(4'b0001, 2'b10, 2'b00, 2'b00, 2'b00);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({sel0, flg0, err0} !== 8'b00011011) begin
      n_bad++;
      $display("FAIL err_present: got %b expected 00011011",
               {sel0, flg0, err0});
    end
    repeat (45) @(posedge CLK);
    #1;
    n_cmp++;
    if ({busy0, err0} !== 2'b01) begin
      n_bad++;
      $display("FAIL err_sticky: got %b expected 01", {busy0, err0});
    end
    pulse_start();
    @(negedge CLK);
    n_cmp++;
    if ({busy0, err0, flg0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL err_clear: got %b expected 10000",
               {busy0, err0, flg0});
    end
  endtask

  task automatic test_relock_start();
    do_reset();
    pulse_start();
    strobe(4'b0010, 2'b00, 2'b00, 2'b00, 2'b00);
    strobe(4'b0010, 2'b00, 2'b10, 2'b00, 2'b00);
    pulse_start();
    @(negedge CLK);
    n_cmp++;
    if ({busy0, err0, sel0} !== 6'b100000) begin
      n_bad++;
      $display("FAIL relock_start: got %b expected 100000",
               {busy0, err0, sel0});
    end
    strobe(4'b1101, 2'b01, 2'b01, 2'b01, 2'b01);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({sel0, flg0} !== 7'b0001011) begin
      n_bad++;
      $display("FAIL relock_flags: got %b expected 0001011",
               {sel0, flg0});
    end
  endtask

  task automatic test_start_strobe();
    do_reset();
    JA = 2'b00;
    EA = 1'b1;
    pulse_start();
    EA = 1'b0;
    strobe(4'b1110, 2'b00, 2'b01, 2'b01, 2'b01);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({busy0, sel0} !== 5'b10000) begin
      n_bad++;
      $display("FAIL start_strobe: got %b expected 10000",
               {busy0, sel0});
    end
    @(posedge CLK);
    #1;
    strobe(4'b0001, 2'b10, 2'b01, 2'b01, 2'b01);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if ({sel0, flg0} !== 7'b0001110) begin
      n_bad++;
      $display("FAIL start_strobe_flags: got %b expected 0001110",
               {sel0, flg0});
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    pulse_start();
    strobe(4'b1111, 2'b10, 2'b10, 2'b10, 2'b10);
    @(posedge CLK);
    #1;
    repeat (22) @(posedge CLK);
    #1;
    @(negedge CLK);
    n_cmp++;
    if (sel0 !== 4'b0100) begin
      n_bad++;
      $display("FAIL mid_in_c: got %b expected 0100", sel0);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    n_cmp++;
    if ({sel0, flg0, busy0, done0, err0} !== 10'b0) begin
      n_bad++;
      $display("FAIL mid_async: got %b expected 0",
               {sel0, flg0, busy0, done0, err0});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    bad = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge CLK);
      if (done0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL mid_no_done: got %0d bad cycles expected 0", bad);
    end
  endtask

  task automatic test_hold1();
    logic [3:0] exp;
    do_reset();
    pulse_start();
    strobe(4'b1111, 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge CLK);
    #1;
    for (int p = 0; p < 4; p++) begin
      exp = 4'b0001 << p;
      @(negedge CLK);
      n_cmp++;
      if (sel1 !== exp || done1 !== 1'b0) begin
        n_bad++;
        $display("FAIL hold1_sel p%0d: got %b/%b expected %b/0",
                 p, sel1, done1, exp);
      end
    end
    @(negedge CLK);
    n_cmp++;
    if ({done1, sel1, flg1} !== 8'b10000001) begin
      n_bad++;
      $display("FAIL hold1_done: got %b expected 10000001",
               {done1, sel1, flg1});
    end
    @(negedge CLK);
    n_cmp++;
    if ({done1, busy1} !== 2'b00) begin
      n_bad++;
      $display("FAIL hold1_idle: got %b expected 00", {done1, busy1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simul();
    test_err();
    test_relock_start();
    test_start_strobe();
    test_reset_mid();
    test_hold1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
